// File: rtl/uart_text_feeder.sv
// rtl/uart_text_feeder.sv - UART receiver, byte FIFO and paced CHAR/WE strobe generator
//
// Receives 8N1 bytes on RX, queues them and hands them to the text driver
// as single-cycle CHAR/WE strobes spaced at least WE_GAP cycles apart.
//
// Ports:
//   CLK_50MHz  in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   RX         in   UART serial input, idle high, asynchronous
//   CHAR       out  [7:0] character, held between strobes
//   WE         out  one-cycle write strobe for CHAR
//   FRAME_ERR  out  sticky: a stop bit was sampled low
//   OVERFLOW   out  sticky: a received byte was dropped on a full FIFO

module uart_text_feeder #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int WE_GAP     = 4800
) (
    input  logic       CLK_50MHz,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] CHAR,
    output logic       WE,
    output logic       FRAME_ERR,
    output logic       OVERFLOW
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int TW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int GW   = $clog2(WE_GAP + 1);

    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [GW-1:0] G_LOAD = GW'(WE_GAP - 1);
    localparam logic [AW:0]   P_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // Synchronizer
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rxs     <= r_rx_meta;
        end
    end

    // Receiver FSM
    state_t        r_state;
    logic [TW-1:0] r_tcnt;
    logic [2:0]    r_bidx;
    logic [7:0]    r_shift;

    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_tcnt    <= '0;
            r_bidx    <= '0;
            r_shift   <= '0;
            FRAME_ERR <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rxs) begin
                        r_state <= ST_START;
                        r_tcnt  <= '0;
                    end
                end
                ST_START: begin
                    if (r_tcnt == T_HALF) begin
                        r_tcnt <= '0;
                        r_bidx <= '0;
                        // A line that is high again at mid start bit was a glitch
                        r_state <= r_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_tcnt == T_FULL) begin
                        r_tcnt  <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bidx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bidx <= r_bidx + 3'd1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_tcnt == T_FULL) begin
                        r_tcnt  <= '0;
                        r_state <= ST_IDLE;
                        if (!r_rxs) begin
                            FRAME_ERR <= 1'b1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // FIFO
    logic [7:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic [GW-1:0] r_gcnt;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == P_FULL);
    assign w_push_req = (r_state == ST_STOP) && (r_tcnt == T_FULL) && r_rxs;
    assign w_pop      = (r_gcnt == '0) && !w_empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge CLK_50MHz) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW + 1)'(1);
            end
            if (w_push_req && !w_push) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    // Pacer
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            r_gcnt <= '0;
            CHAR   <= 8'h00;
            WE     <= 1'b0;
        end else begin
            if (w_pop) begin
                CHAR   <= r_mem[r_rptr[AW-1:0]];
                WE     <= 1'b1;
                r_gcnt <= G_LOAD;
            end else begin
                WE <= 1'b0;
                if (r_gcnt != '0) begin
                    r_gcnt <= r_gcnt - GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_text_feeder.sv
// tb/tb_uart_text_feeder.sv - self-checking bench for uart_text_feeder

module tb_uart_text_feeder;

    localparam int DIV    = 8;
    localparam int HALF   = DIV / 2;
    localparam int WE_GAP = 2000;
    localparam int LAT    = 4 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] ch;
    logic       we;
    logic       fe;
    logic       ov;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;
    logic [7:0] exp_q[$];
    int         we_cyc[$];
    logic       prev_we = 1'b0;
    logic [7:0] e;

    uart_text_feeder #(
        .CLK_HZ    (800000),
        .BAUD      (100000),
        .FIFO_DEPTH(16),
        .WE_GAP    (WE_GAP)
    ) dut (
        .CLK_50MHz(clk),
        .RESET    (rst),
        .RX       (rx),
        .CHAR     (ch),
        .WE       (we),
        .FRAME_ERR(fe),
        .OVERFLOW (ov)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe pops one expected character
    always @(negedge clk) begin
        if (we === 1'b1) begin
            total++;
            assert (prev_we === 1'b0) else begin
                bad++;
                $error("FAIL we_width observed=%0b expected=0 (WE high two cycles)", prev_we);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_we observed CHAR=%02h expected no strobe", ch);
            end else begin
                e = exp_q.pop_front();
                assert (ch === e) else begin
                    bad++;
                    $error("FAIL char observed=%02h expected=%02h", ch, e);
                end
            end
            we_cyc.push_back(cyc);
        end
        prev_we = we;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (DIV) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60000) begin
            @(posedge clk);
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
        end
        repeat (WE_GAP + 10) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_char", ch, 0);
        chk("reset_we", we, 0);
        chk("reset_fe", fe, 0);
        chk("reset_ov", ov, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single byte with latency
        we_cyc.delete();
        t0 = cyc;
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1);
        drain();
        chk("t1_count", we_cyc.size(), 1);
        chk("t1_latency", we_cyc[0] - t0, LAT);
        chk("t1_fe", fe, 0);
        chk("t1_ov", ov, 0);

        // Three back-to-back bytes, spacing exactly WE_GAP
        we_cyc.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h0A);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h0A, 1'b1);
        drain();
        chk("t2_count", we_cyc.size(), 3);
        chk("t2_gap1", we_cyc[1] - we_cyc[0], WE_GAP);
        chk("t2_gap2", we_cyc[2] - we_cyc[1], WE_GAP);

        // Short glitch then a valid byte
        we_cyc.delete();
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("t3_glitch_we", we_cyc.size(), 0);
        chk("t3_glitch_fe", fe, 0);
        exp_q.push_back(8'h7F);
        send_byte(8'h7F, 1'b1);
        drain();
        chk("t3_count", we_cyc.size(), 1);

        // Frame error, then a valid byte; flag stays sticky
        we_cyc.delete();
        send_byte(8'h55, 1'b0);
        repeat (4 * DIV) @(posedge clk);
        #1;
        chk("t4_fe_set", fe, 1);
        chk("t4_no_we", we_cyc.size(), 0);
        exp_q.push_back(8'h31);
        send_byte(8'h31, 1'b1);
        drain();
        chk("t4_count", we_cyc.size(), 1);
        chk("t4_fe_sticky", fe, 1);

        // Overflow: 18 back-to-back bytes, last one dropped
        we_cyc.delete();
        chk("t5_ov_before", ov, 0);
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 18; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_ov_set", ov, 1);
        drain();
        chk("t5_count", we_cyc.size(), 17);
        for (int i = 1; i < 17; i++) chk($sformatf("t5_gap%0d", i), we_cyc[i] - we_cyc[i-1], WE_GAP);

        // Reset during DATA of 0x5A
        we_cyc.delete();
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (DIV) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_char", ch, 0);
        chk("t6_rst_we", we, 0);
        chk("t6_rst_fe", fe, 0);
        chk("t6_rst_ov", ov, 0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (12 * DIV) @(posedge clk);
        #1;
        chk("t6_no_we", we_cyc.size(), 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        drain();
        chk("t6_count", we_cyc.size(), 1);
        chk("t6_fe", fe, 0);
        chk("end_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
